// File: rtl/txarb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : txarb_pkg
// Purpose  : Shared types and constants for the txuart packet arbiter.
// Options  : TXARB_HEADER_EN - adds the HDR state (source-ID header byte)
// Revision : 1.0 - initial release
// ============================================================================
package txarb_pkg;

`ifdef TXARB_HEADER_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } txarb_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd2
    } txarb_state_t;
`endif

    localparam logic [7:0] TXARB_HDR_MARK = 8'h80;

endpackage
`default_nettype wire

// File: rtl/txarb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : txarb_rr_pick
// Purpose  : Combinational round-robin picker; searches from i_ptr+1 upward,
//            wrapping modulo NUM_SRC, and returns the first requester.
// Revision : 1.0 - initial release
// ============================================================================
module txarb_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_SRC-1:0] o_grant,
    output logic [ID_W-1:0]    o_id,
    output logic               o_any
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = ID_W'((int'(i_ptr) + k) % NUM_SRC);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/txuart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : txuart_arbiter
// Purpose  : Packet-level round-robin arbiter sharing one txuart among
//            NUM_SRC byte-stream sources, with optional stall timeout.
// Options  : TXARB_HEADER_EN - prefix each packet with 8'h80 | source ID
// Revision : 1.0 - initial release
// ============================================================================
module txuart_arbiter
    import txarb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [NUM_SRC-1:0]         i_valid,
    input  logic [8*NUM_SRC-1:0]       i_data,
    input  logic [NUM_SRC-1:0]         i_last,
    output logic [NUM_SRC-1:0]         o_ready,
    output logic                       o_tx_wr,
    output logic [7:0]                 o_tx_data,
    input  logic                       i_tx_busy,
    output logic [NUM_SRC-1:0]         o_grant,
    output logic                       o_active,
    output logic                       o_abort,
    output logic [$clog2(NUM_SRC)-1:0] o_abort_src
);

    localparam int ID_W  = $clog2(NUM_SRC);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    txarb_state_t       r_state;
    txarb_state_t       w_state_next;
    logic [NUM_SRC-1:0] r_grant;
    logic [ID_W-1:0]    r_gid;
    logic [ID_W-1:0]    r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_abort;
    logic [ID_W-1:0]    r_abort_src;

    logic [NUM_SRC-1:0] w_pick_grant;
    logic [ID_W-1:0]    w_pick_id;
    logic               w_pick_any;
    logic               w_src_valid;
    logic               w_src_last;
    logic               w_acc;
    logic               w_done;
    logic               w_timeout;
    logic [7:0]         w_src_data [NUM_SRC];

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
            assign w_src_data[k] = i_data[8*k +: 8];
        end
    endgenerate

    txarb_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (i_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_id    (w_pick_id),
        .o_any   (w_pick_any)
    );

    assign w_src_valid = i_valid[r_gid];
    assign w_src_last  = i_last[r_gid];

    always_comb begin
        w_state_next = r_state;
        o_tx_wr      = 1'b0;
        o_tx_data    = '0;
        o_ready      = '0;
        w_acc        = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef TXARB_HEADER_EN
                if (w_pick_any) w_state_next = HDR;
`else
                if (w_pick_any) w_state_next = DATA;
`endif
            end
`ifdef TXARB_HEADER_EN
            HDR: begin
                o_tx_wr   = 1'b1;
                o_tx_data = TXARB_HDR_MARK | 8'(r_gid);
                w_acc     = !i_tx_busy;
                if (w_acc) w_state_next = DATA;
            end
`endif
            DATA: begin
                o_tx_wr   = w_src_valid;
                o_tx_data = w_src_data[r_gid];
                w_acc     = w_src_valid && !i_tx_busy;
                if (w_acc) o_ready = r_grant;
                w_done    = w_acc && w_src_last;
                // A source re-raising valid in the limit cycle clears the counter instead
                w_timeout = (TIMEOUT != 0) && !w_src_valid && (r_cnt == c_cnt_last);
                if (w_done || w_timeout) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_grant     <= '0;
            r_gid       <= '0;
            r_ptr       <= ID_W'(NUM_SRC - 1);
            r_cnt       <= '0;
            r_abort     <= 1'b0;
            r_abort_src <= '0;
        end else begin
            r_abort <= 1'b0;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_pick_any) begin
                    r_grant <= w_pick_grant;
                    r_gid   <= w_pick_id;
                end
            end else if (r_state == DATA) begin
                if (w_done || w_timeout) begin
                    r_grant <= '0;
                    r_ptr   <= r_gid;
                end
                if (w_timeout) begin
                    r_abort     <= 1'b1;
                    r_abort_src <= r_gid;
                end
                if (w_acc || w_src_valid) r_cnt <= '0;
                else if (TIMEOUT != 0)    r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_grant     = r_grant;
    assign o_active    = (r_state != IDLE);
    assign o_abort     = r_abort;
    assign o_abort_src = r_abort_src;

endmodule
`default_nettype wire

// File: doc/txuart_arbiter.md
# txuart_arbiter

Packet-level round-robin arbiter that shares one `txuart` transmitter among `NUM_SRC` byte-stream sources. It grants one source at a time and forwards that source's whole packet, ending at the byte flagged `last`, through the `txuart` `i_wr`/`i_data`/`o_busy` handshake. It optionally prefixes each packet with a source-ID header byte and aborts a stalled packet after a timeout. It sits between the application message producers and `txuart`.

## Interface
- `NUM_SRC`, 4: number of sources, 2..8.
- `TIMEOUT`, 1000: clock cycles a granted source may hold `valid` low mid-packet before abort; 0 disables the timeout.
- `i_clk` in 1: the single clock.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_valid` in NUM_SRC: per-source byte valid.
- `i_data` in 8*NUM_SRC: per-source byte; source k occupies bits [8k+7:8k].
- `i_last` in NUM_SRC: per-source last-byte-of-packet flag, qualified by `i_valid`.
- `o_ready` out NUM_SRC: per-source byte accepted this cycle.
- `o_tx_wr` out 1: drives `txuart` `i_wr`.
- `o_tx_data` out 8: drives `txuart` `i_data`.
- `i_tx_busy` in 1: from `txuart` `o_busy`.
- `o_grant` out NUM_SRC: one-hot current grant, registered.
- `o_active` out 1: a packet is in progress, i.e. the state is HDR or DATA.
- `o_abort` out 1: one-cycle pulse, registered, when a packet is aborted by timeout.
- `o_abort_src` out $clog2(NUM_SRC): ID of the aborted source; held until the next abort.

## Operation
- Accept rule: a byte is transferred to `txuart` in any cycle where `o_tx_wr && !i_tx_busy`. Call this `acc`.
- Reset values: state IDLE, `o_grant`=0, `o_abort`=0, `o_abort_src`=0, round-robin pointer = NUM_SRC-1 (source 0 has priority first), timeout counter 0.
- Combinational outputs are 0 while in IDLE: `o_tx_wr`, `o_tx_data`, `o_ready`.
- State IDLE:
  - If any `i_valid` is set, pick the first set bit searching from pointer+1, wrapping modulo NUM_SRC.
  - Register `o_grant` and the granted ID `g`.
  - Go to HDR if the header feature is compiled in, otherwise go to DATA.
- State HDR:
  - `o_tx_wr`=1, `o_tx_data` = 8'h80 | g.
  - `o_ready`=0.
  - On `acc`, go to DATA.
- State DATA:
  - `o_tx_wr` = `i_valid[g]`, `o_tx_data` = `i_data[g]`.
  - `o_ready[g]` = `acc`; all other `o_ready` bits are 0.
  - On `acc && i_last[g]`: go to IDLE, set pointer = g, clear `o_grant`.
- Timeout, active only in DATA and only when TIMEOUT≠0:
  - Counter clears on `acc`, on `i_valid[g]`, and on entry to DATA.
  - Otherwise the counter increments.
  - When `!i_valid[g]` and counter == TIMEOUT-1: go to IDLE, pointer = g, `o_abort`<=1, `o_abort_src`<=g.
- Non-granted sources are never acknowledged. Their `i_valid` is ignored until they are granted.
- `i_last` while in HDR is ignored.
- A packet with a single `last` byte is legal.
- Reset asserted mid-packet: everything returns to reset values immediately. A byte already handed to `txuart` completes there. The packet is lost, with no abort pulse.

## Timing
- Arbitration takes one cycle. A request seen in IDLE at cycle n gives `o_grant` and `o_tx_wr` at cycle n+1.
- Byte throughput is set by `txuart`. `o_tx_wr` is held until `acc`. Because `i_tx_busy` is registered, back-to-back `acc` cannot occur.
- After a packet's final `acc`, there is one IDLE cycle before the next grant. New requests made during the final `acc` cycle are arbitrated in that IDLE cycle.
- `o_abort` asserts in the cycle following the timeout detection. In that cycle `o_grant` is already 0.
- Valid dropping and rising in the same cycle that the counter reaches TIMEOUT-1: no abort, because `i_valid[g]` clears the counter.
- Asserting `i_valid` while `i_tx_busy` is high does not advance the timeout.

## Configuration
- `TXARB_HEADER_EN`:
  - Defined: HDR state exists. Each packet is preceded by 8'h80|ID, so a packet of N bytes costs N+1 `acc`.
  - Undefined: IDLE goes directly to DATA. No header is sent, and the HDR encoding is absent.

## Structure
- Package `txarb_pkg`:
  - State enum `txarb_state_t` {IDLE, HDR, DATA}.
  - Constant `TXARB_HDR_MARK` = 8'h80.
- Sub-module `txarb_rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, binary ID, any-request flag.

## Test plan
- NUM_SRC=4, header on, source 2 sends 3 bytes {11,22,33 with last}, `i_tx_busy` emulated at 10 cycles per byte → `txuart` sees 82,11,22,33, then `o_active` falls and `o_grant`=0.
- Sources 0, 1 and 3 all request 1-byte packets continuously → grant order 0,1,3,0,1,3, with exactly one IDLE cycle between packets.
- Header off, source 1 sends a single byte with `last` → one `acc` only, `o_ready[1]` pulses exactly once, in the `acc` cycle.
- TIMEOUT=8, source 0 sends 1 byte without `last` then drops valid → `o_abort`=1 for one cycle and `o_abort_src`=0, 9 cycles after the last `acc`; the next request is granted to source 1 before source 0.
- Assert `i_reset_n`=0 mid-packet while `i_tx_busy`=1 → `o_tx_wr`, `o_grant` and `o_ready` go to 0 asynchronously. After release, the first grant goes to source 0.
- `i_tx_busy` held high for 500 cycles with TIMEOUT=8 and valid held → no abort, and the byte is accepted when busy falls.
